sram_bus_master: RTL and testbench

- Initiator side of the team's single-port SRAM bus (addr, bidirectional data, cs, we, oe; synchronous write; registered read data driven when cs && oe && !we).
- Accepts single-beat read/write requests on a valid/ready host interface and sequences the SRAM control strobes.
- Owns the tristate data bus while writing and returns read data on a valid/ready response channel.
- Sits between a host engine (DMA, CPU bridge) and one singleportram instance.

---
 rtl/sram_bus_master.sv | 134 +++++++++++++
 tb/tb_sram_bus_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_master.sv
// Single-beat initiator for the single-port SRAM bus: sequences cs/we/oe and owns the data bus on writes.
// Latency: write strobes 1 cycle after accept; read response valid 2 edges after accept.
// Backpressure: req_ready only in IDLE; response held in RSP until rsp_ready.
module sram_bus_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        RSP     = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    mem_cs_q, mem_cs_d;
    logic                    mem_we_q, mem_we_d;
    logic                    mem_oe_q, mem_oe_d;
    logic                    drv_en_q, drv_en_d;
    logic                    rsp_valid_q, rsp_valid_d;

    // Strobes are computed for the state being entered so they come straight off flops.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_valid_d = rsp_valid_q;
        mem_cs_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_oe_d    = 1'b0;
        drv_en_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mem_addr_d = req_addr;
                    wdata_d    = req_wdata;
                    mem_cs_d   = 1'b1;
                    if (req_we) begin
                        state_d  = WR;
                        mem_we_d = 1'b1;
                        drv_en_d = 1'b1;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RD_ADDR: begin
                state_d  = RD_DATA;
                mem_cs_d = 1'b1;
                mem_oe_d = 1'b1;
            end
            RD_DATA: begin
                rsp_rdata_d = mem_data;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
            drv_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_valid_q <= rsp_valid_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_oe_q    <= mem_oe_d;
            drv_en_q    <= drv_en_d;
        end
    end

    assign req_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_oe    = mem_oe_q;
    assign mem_data  = drv_en_q ? wdata_q : {DATA_WIDTH{1'bz}};

    // Bus contention guards: master drives only on writes, never against the SRAM, with a dead cycle between.
    a_drv_we : assert property (@(posedge clk) disable iff (rst) drv_en_q |-> mem_we_q);
    a_no_contention : assert property (@(posedge clk) !(drv_en_q && mem_oe_q));
    a_turnaround : assert property (@(posedge clk) disable iff (rst) drv_en_q |-> !$past(mem_oe_q));

endmodule

// File: tb/tb_sram_bus_master.sv
// Bench for sram_bus_master: behavioural SRAM, reference memory and response/write scoreboards.
module tb_sram_bus_master;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;
    logic          mem_cs;
    logic          mem_we;
    logic          mem_oe;

    sram_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_oe    (mem_oe)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM: synchronous write, registered read driven while cs && oe && !we.
    logic [DW-1:0] sram [256];
    logic [DW-1:0] sram_rd;
    always @(posedge clk) begin
        if (mem_cs && mem_we) sram[mem_addr] <= mem_data;
        if (mem_cs && !mem_we) sram_rd <= sram[mem_addr];
    end
    assign mem_data = (mem_cs && mem_oe && !mem_we) ? sram_rd : {DW{1'bz}};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic [DW-1:0] ref_mem [256];
    logic [AW-1:0] waddrs[$];
    logic [DW-1:0] rd_exp_q[$];
    wr_t           wr_exp_q[$];
    int            acc_cyc = 0;
    int            rdy_mode = 0;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: bus invariants, write strobes, response timing and read data.
    logic    prev_vld = 1'b0;
    logic    prev_oe = 1'b0;
    logic    prev_drv = 1'b0;
    logic    hs = 1'b0;
    logic [DW-1:0] prev_rdata = '0;
    wr_t     w;
    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
            prev_oe  = 1'b0;
            prev_drv = 1'b0;
            hs       = 1'b0;
        end else begin
            chk("drv_without_we", 32'(dut.drv_en_q & ~mem_we), 0);
            chk("drv_with_oe", 32'(dut.drv_en_q & mem_oe), 0);
            if (dut.drv_en_q) chk("turnaround_to_write", 32'(prev_oe), 0);
            if (mem_oe) chk("turnaround_to_read", 32'(prev_drv), 0);
            if (mem_cs && mem_we) begin
                if (wr_exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    w = wr_exp_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(w.a));
                    chk("wr_data", 32'(mem_data), 32'(w.d));
                end
            end
            if (hs) begin
                chk("rsp_release", 32'(rsp_valid), 0);
            end else if (prev_vld) begin
                chk("rsp_hold", 32'(rsp_valid), 1);
                chk("rsp_stable", 32'(rsp_rdata), 32'(prev_rdata));
            end
            if (rsp_valid && !prev_vld) chk("rd_latency", 32'(cyc - acc_cyc), 2);
            if (rsp_valid) chk("req_ready_in_rsp", 32'(req_ready), 0);
            hs = rsp_valid && rsp_ready;
            if (hs) begin
                if (rd_exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
                else chk("rd_data", 32'(rsp_rdata), 32'(rd_exp_q.pop_front()));
            end
            prev_vld   = rsp_valid;
            prev_rdata = rsp_rdata;
            prev_oe    = mem_oe;
            prev_drv   = dut.drv_en_q;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge, with request inputs scrambled.
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1;
                break;
            end
        end
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            if (we) begin
                ref_mem[a] = d;
                waddrs.push_back(a);
                wr_exp_q.push_back('{a, d});
            end else begin
                rd_exp_q.push_back(ref_mem[a]);
                acc_cyc = cyc + 1;
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            req_we    = 1'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] a;
        bit got;
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_cs", 32'(mem_cs), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_oe", 32'(mem_oe), 0);
        chk("rst_drv", 32'(dut.drv_en_q), 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        @(posedge clk);
        #1;

        issue(1'b1, 8'h10, 8'hA5);
        issue(1'b0, 8'h10, 8'h00);
        wait_idle();

        // Response backpressure on the all-ones address.
        issue(1'b1, 8'hFF, 8'h3C);
        rdy_mode = 1;
        issue(1'b0, 8'hFF, 8'h00);
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                break;
            end
        end
        chk("rsp_seen", 32'(got), 1);
        for (int n = 0; n < 5; n++) begin
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_rdata", 32'(rsp_rdata), 32'h3C);
            chk("bp_req_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        rdy_mode = 0;
        wait_idle();

        // Read-then-write turnaround on the same address.
        issue(1'b1, 8'h01, 8'h11);
        issue(1'b0, 8'h01, 8'h00);
        issue(1'b1, 8'h01, 8'h77);
        issue(1'b0, 8'h01, 8'h00);
        wait_idle();

        // Reset while in RD_DATA discards the read.
        issue(1'b0, 8'h10, 8'h00);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rd_exp_q.delete();
        @(negedge clk);
        chk("mid_rst_cs", 32'(mem_cs), 0);
        chk("mid_rst_we", 32'(mem_we), 0);
        chk("mid_rst_oe", 32'(mem_oe), 0);
        chk("mid_rst_drv", 32'(dut.drv_en_q), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        issue(1'b1, 8'h02, 8'h5A);
        issue(1'b0, 8'h02, 8'h00);
        wait_idle();

        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = ($urandom_range(0, 7) == 0) ? 8'hFF : AW'($urandom_range(0, 15));
                issue(1'b1, a, DW'($urandom));
            end else begin
                a = waddrs[$urandom_range(0, waddrs.size() - 1)];
                issue(1'b0, a, DW'($urandom));
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();
        repeat (3) @(posedge clk);
        chk("rd_queue_drained", 32'(rd_exp_q.size()), 0);
        chk("wr_queue_drained", 32'(wr_exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
